// File: rtl/aes_steg_pkg.sv
// rtl/aes_steg_pkg.sv - state encoding and sizing helpers for the AES/stego frame sequencer
package aes_steg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_ENC  = 2'd2,
    ST_HOLD = 2'd3
  } seq_state_t;

  // Bits needed to index one block's serial bit position.
  function automatic int bit_cnt_w(input int blk_w);
    return $clog2(blk_w);
  endfunction

  // Bits needed to count 0..nblk encrypted blocks.
  function automatic int blk_cnt_w(input int nblk);
    return $clog2(nblk + 1);
  endfunction

  // FIFO pointer: address bits plus one wrap bit.
  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  // FIFO occupancy 0..depth.
  function automatic int level_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/steg_fifo.sv
// rtl/steg_fifo.sv - synchronous ciphertext FIFO with wrap-bit pointers
module steg_fifo
  import aes_steg_pkg::*;
#(
  parameter int WIDTH = 129,
  parameter int DEPTH = 4
) (
  input  logic                        i_clk,
  input  logic                        i_rst_n,
  input  logic                        i_wr_en,
  input  logic [WIDTH-1:0]            i_wr_data,
  input  logic                        i_rd_en,
  output logic [WIDTH-1:0]            o_rd_data,
  output logic                        o_full,
  output logic                        o_empty,
  output logic [level_w(DEPTH)-1:0]   o_level
);
  localparam int PW = ptr_w(DEPTH);
  localparam int AW = PW - 1;
  localparam int LW = level_w(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [PW-1:0]    w_diff;
  logic             w_wr;
  logic             w_rd;

  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_full    = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) && (r_wr_ptr[AW] != r_rd_ptr[AW]);
  assign w_wr      = i_wr_en && !o_full;
  assign w_rd      = i_rd_en && !o_empty;
  assign w_diff    = r_wr_ptr - r_rd_ptr;
  assign o_level   = LW'(w_diff);
  assign o_rd_data = r_mem[r_rd_ptr[AW-1:0]];

  // Pointer and storage update; full/empty guards make overflow and underflow impossible.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (w_wr) begin
        r_mem[r_wr_ptr[AW-1:0]] <= i_wr_data;
        r_wr_ptr                <= r_wr_ptr + 1'b1;
      end
      if (w_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/aes_steg_sequencer.sv
// rtl/aes_steg_sequencer.sv - serial load, AES-CBC launch/chaining and stego drain sequencer
module aes_steg_sequencer
  import aes_steg_pkg::*;
#(
  parameter int BLK_W = 128,
  parameter int DEPTH = 4,
  parameter int NBLK  = 8,
  parameter int CBC   = 1
) (
  input  logic                        i_clk,
  input  logic                        i_rst_n,
  input  logic                        i_start,
  input  logic                        i_bit_valid,
  input  logic                        i_key_bit,
  input  logic                        i_payload_bit,
  input  logic                        i_iv_bit,
  output logic [BLK_W-1:0]            o_aes_key,
  output logic [BLK_W-1:0]            o_aes_data,
  output logic [BLK_W-1:0]            o_aes_iv,
  output logic                        o_aes_start,
  input  logic                        i_aes_done,
  input  logic [BLK_W-1:0]            i_aes_ct,
  output logic [BLK_W-1:0]            o_steg_payload,
  output logic                        o_steg_valid,
  input  logic                        i_steg_ready,
  output logic [blk_cnt_w(NBLK)-1:0]  o_blk_cnt,
  output logic [level_w(DEPTH)-1:0]   o_fifo_level,
  output logic                        o_busy,
  output logic                        o_frame_done,
  output logic                        o_err_spurious
);
  localparam int CW = bit_cnt_w(BLK_W);
  localparam int BW = blk_cnt_w(NBLK);
  localparam logic [CW-1:0] LAST_BIT = CW'(BLK_W - 1);
  localparam logic [BW-1:0] LAST_BLK = BW'(NBLK - 1);

  seq_state_t       r_state;
  seq_state_t       w_state_nxt;
  logic [CW-1:0]    r_bit_cnt;
  logic [BW-1:0]    r_blk_cnt;
  logic [BLK_W-1:0] r_key;
  logic [BLK_W-1:0] r_data;
  logic [BLK_W-1:0] r_iv;
  logic [BLK_W-1:0] r_hold;
  logic             r_aes_start;
  logic             r_err;
  logic             r_steg_valid;
  logic             r_steg_last;
  logic [BLK_W-1:0] r_steg_payload;
  logic             w_shift;
  logic             w_last_bit;
  logic             w_last_blk;
  logic             w_wr_en;
  logic [BLK_W-1:0] w_wr_data;
  logic             w_full;
  logic             w_empty;
  logic             w_xfer;
  logic             w_pop;
  logic [BLK_W:0]   w_rd_word;

  assign w_shift    = (r_state == ST_LOAD) && i_bit_valid;
  assign w_last_bit = w_shift && (r_bit_cnt == LAST_BIT);
  assign w_last_blk = (r_blk_cnt == LAST_BLK);
  assign w_xfer     = r_steg_valid && i_steg_ready;
  assign w_pop      = (!r_steg_valid || w_xfer) && !w_empty;

  assign o_aes_key      = r_key;
  assign o_aes_data     = r_data;
  assign o_aes_iv       = (CBC != 0) ? r_iv : '0;
  assign o_aes_start    = r_aes_start;
  assign o_steg_payload = r_steg_payload;
  assign o_steg_valid   = r_steg_valid;
  assign o_blk_cnt      = r_blk_cnt;
  assign o_busy         = (r_state != ST_IDLE) || !w_empty;
  assign o_frame_done   = w_xfer && r_steg_last;
  assign o_err_spurious = r_err;

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Next state and FIFO write source; a full FIFO parks the ciphertext in HOLD.
  always_comb begin
    w_state_nxt = r_state;
    w_wr_en     = 1'b0;
    w_wr_data   = i_aes_ct;
    case (r_state)
      ST_IDLE: if (i_start) w_state_nxt = ST_LOAD;
      ST_LOAD: if (w_last_bit) w_state_nxt = ST_ENC;
      ST_ENC: begin
        if (i_aes_done) begin
          if (w_full) begin
            w_state_nxt = ST_HOLD;
          end else begin
            w_wr_en     = 1'b1;
            w_state_nxt = w_last_blk ? ST_IDLE : ST_LOAD;
          end
        end
      end
      ST_HOLD: begin
        w_wr_data = r_hold;
        if (!w_full) begin
          w_wr_en     = 1'b1;
          w_state_nxt = w_last_blk ? ST_IDLE : ST_LOAD;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Load shifting, launch pulse, block counting and CBC chaining.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_bit_cnt   <= '0;
      r_blk_cnt   <= '0;
      r_key       <= '0;
      r_data      <= '0;
      r_iv        <= '0;
      r_hold      <= '0;
      r_aes_start <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_aes_start <= w_last_bit;
      if ((r_state == ST_IDLE) && i_start) begin
        r_bit_cnt <= '0;
        r_blk_cnt <= '0;
      end
      if (w_shift) begin
        r_bit_cnt <= w_last_bit ? '0 : r_bit_cnt + 1'b1;
        r_data    <= {r_data[BLK_W-2:0], i_payload_bit};
        if (r_blk_cnt == '0) begin
          r_key <= {r_key[BLK_W-2:0], i_key_bit};
          r_iv  <= {r_iv[BLK_W-2:0], i_iv_bit};
        end
      end
      if ((r_state == ST_ENC) && i_aes_done && w_full) r_hold <= i_aes_ct;
      if (w_wr_en) begin
        r_blk_cnt <= r_blk_cnt + 1'b1;
        r_bit_cnt <= '0;
        if (CBC != 0) r_iv <= w_wr_data;
      end
      if (i_aes_done && (r_state != ST_ENC)) r_err <= 1'b1;
    end
  end

  // Drain register toward the stego core; refills on the transfer cycle for back-to-back blocks.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_steg_valid   <= 1'b0;
      r_steg_last    <= 1'b0;
      r_steg_payload <= '0;
    end else if (w_pop) begin
      r_steg_valid   <= 1'b1;
      r_steg_last    <= w_rd_word[BLK_W];
      r_steg_payload <= w_rd_word[BLK_W-1:0];
    end else if (w_xfer) begin
      r_steg_valid <= 1'b0;
      r_steg_last  <= 1'b0;
    end
  end

  steg_fifo #(
    .WIDTH (BLK_W + 1),
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_wr_en   (w_wr_en),
    .i_wr_data ({w_last_blk, w_wr_data}),
    .i_rd_en   (w_pop),
    .o_rd_data (w_rd_word),
    .o_full    (w_full),
    .o_empty   (w_empty),
    .o_level   (o_fifo_level)
  );

endmodule

// File: tb/tb_aes_steg_sequencer.sv
// tb/tb_aes_steg_sequencer.sv - randomized frame bench with CBC and ECB instances in lockstep
module tb_aes_steg_sequencer;
  localparam int BLK_W = 8;
  localparam int DEPTH = 2;
  localparam int NBLK  = 4;

  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, bit_valid = 1'b0;
  logic key_bit = 1'b0, payload_bit = 1'b0, iv_bit = 1'b0, aes_done = 1'b0, steg_ready = 1'b0;
  logic [7:0] aes_ct = 8'h00;

  logic [7:0] aes_key, aes_data, aes_iv, steg_payload;
  logic       aes_start, steg_valid, busy, frame_done, err_spurious;
  logic [2:0] blk_cnt;
  logic [1:0] fifo_level;

  logic [7:0] e_aes_key, e_aes_data, e_aes_iv, e_steg_payload;
  logic       e_aes_start, e_steg_valid, e_busy, e_frame_done, e_err_spurious;
  logic [2:0] e_blk_cnt;
  logic [1:0] e_fifo_level;

  int total = 0;
  int bad   = 0;

  logic [8:0] exp_q[$];
  logic [8:0] got_q[$];

  always #5 clk = ~clk;

  aes_steg_sequencer #(.BLK_W(BLK_W), .DEPTH(DEPTH), .NBLK(NBLK), .CBC(1)) u_dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_bit_valid(bit_valid),
    .i_key_bit(key_bit), .i_payload_bit(payload_bit), .i_iv_bit(iv_bit),
    .o_aes_key(aes_key), .o_aes_data(aes_data), .o_aes_iv(aes_iv), .o_aes_start(aes_start),
    .i_aes_done(aes_done), .i_aes_ct(aes_ct), .o_steg_payload(steg_payload),
    .o_steg_valid(steg_valid), .i_steg_ready(steg_ready), .o_blk_cnt(blk_cnt),
    .o_fifo_level(fifo_level), .o_busy(busy), .o_frame_done(frame_done),
    .o_err_spurious(err_spurious)
  );

  aes_steg_sequencer #(.BLK_W(BLK_W), .DEPTH(DEPTH), .NBLK(NBLK), .CBC(0)) u_ecb (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_bit_valid(bit_valid),
    .i_key_bit(key_bit), .i_payload_bit(payload_bit), .i_iv_bit(iv_bit),
    .o_aes_key(e_aes_key), .o_aes_data(e_aes_data), .o_aes_iv(e_aes_iv), .o_aes_start(e_aes_start),
    .i_aes_done(aes_done), .i_aes_ct(aes_ct), .o_steg_payload(e_steg_payload),
    .o_steg_valid(e_steg_valid), .i_steg_ready(steg_ready), .o_blk_cnt(e_blk_cnt),
    .o_fifo_level(e_fifo_level), .o_busy(e_busy), .o_frame_done(e_frame_done),
    .o_err_spurious(e_err_spurious)
  );

  // Record every stego transfer of the CBC instance with its frame_done flag.
  always @(negedge clk) begin
    if (rst_n && steg_valid && steg_ready) got_q.push_back({frame_done, steg_payload});
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Shift one block MSB first with random idle gaps; key/iv lines carry junk after block 0.
  task automatic shift_block(input int b, input logic [7:0] key, input logic [7:0] iv,
                             input logic [7:0] pt, input int spur_blk, input bit rnd_ready);
    for (int i = 7; i >= 0; i--) begin
      while ($urandom_range(0, 3) == 0) begin
        bit_valid = 1'b0;
        key_bit = 1'($urandom);
        payload_bit = 1'($urandom);
        if (rnd_ready) steg_ready = 1'($urandom);
        tick;
      end
      if ((b == spur_blk) && (i == 4)) begin
        bit_valid = 1'b0;
        aes_done = 1'b1;
        tick;
        aes_done = 1'b0;
        check("spur_err", err_spurious, 1);
        check("spur_err_ecb", e_err_spurious, 1);
        check("spur_blk_cnt", blk_cnt, b);
        check("spur_level", fifo_level, 0);
      end
      bit_valid   = 1'b1;
      payload_bit = pt[i];
      key_bit     = (b == 0) ? key[i] : 1'($urandom);
      iv_bit      = (b == 0) ? iv[i] : 1'($urandom);
      start       = ((b == 1) && (i == 7)) ? 1'b1 : 1'b0;
      if (rnd_ready) steg_ready = 1'($urandom);
      tick;
      start = 1'b0;
    end
    bit_valid = 1'b0;
  endtask

  task automatic check_launch(input logic [7:0] key, input logic [7:0] iv, input logic [7:0] pt);
    check("aes_start", aes_start, 1);
    check("aes_key", aes_key, key);
    check("aes_data", aes_data, pt);
    check("aes_iv", aes_iv, iv);
    check("ecb_start", e_aes_start, 1);
    check("ecb_key", e_aes_key, key);
    check("ecb_iv_zero", e_aes_iv, 0);
    tick;
    check("aes_start_once", aes_start, 0);
  endtask

  task automatic run_frame(input int spur_blk, input bit bp, input bit rnd_ready);
    logic [7:0] key, iv, pt, ct, chain;
    key = 8'($urandom);
    iv  = 8'($urandom);
    chain = iv;
    steg_ready = !bp;
    start = 1'b1;
    tick;
    start = 1'b0;
    for (int b = 0; b < NBLK; b++) begin
      pt = 8'($urandom);
      shift_block(b, key, iv, pt, spur_blk, rnd_ready);
      check_launch(key, chain, pt);
      repeat ($urandom_range(0, 3)) tick;
      if (rnd_ready) begin
        steg_ready = 1'b1;
        tick;
        tick;
      end
      ct = 8'($urandom);
      if (bp && (b == NBLK - 1)) check("bp_level_full", fifo_level, DEPTH);
      aes_done = 1'b1;
      aes_ct   = ct;
      tick;
      aes_done = 1'b0;
      exp_q.push_back({(b == NBLK - 1), ct});
      chain = ct;
      if (bp && (b == NBLK - 1)) begin
        check("hold_blk_cnt", blk_cnt, NBLK - 1);
        repeat (3) tick;
        check("hold_level", fifo_level, DEPTH);
        check("hold_blk_cnt_stable", blk_cnt, NBLK - 1);
        check("hold_busy", busy, 1);
        steg_ready = 1'b1;
        for (int t = 0; t < 20 && blk_cnt != 3'(NBLK); t++) tick;
      end
      check("blk_cnt", blk_cnt, b + 1);
    end
    steg_ready = 1'b1;
    for (int t = 0; t < 60 && (got_q.size() < exp_q.size() || busy); t++) tick;
    tick;
    check("stream_len", got_q.size(), exp_q.size());
    for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) check("stream_blk", got_q[k], exp_q[k]);
    check("idle_busy", busy, 0);
    check("idle_valid", steg_valid, 0);
    check("ecb_blk_cnt", e_blk_cnt, NBLK);
    exp_q.delete();
    got_q.delete();
  endtask

  initial begin
    logic [7:0] key, iv, pt;
    #2;
    check("rst_key", aes_key, 0);
    check("rst_start", aes_start, 0);
    check("rst_valid", steg_valid, 0);
    check("rst_level", fifo_level, 0);
    check("rst_busy", busy, 0);
    check("rst_blk_cnt", blk_cnt, 0);
    check("rst_err", err_spurious, 0);
    tick;
    rst_n = 1'b1;
    tick;

    run_frame(-1, 1'b0, 1'b0);
    run_frame(-1, 1'b0, 1'b1);
    run_frame(-1, 1'b0, 1'b1);
    check("no_spur_yet", err_spurious, 0);
    run_frame(2, 1'b0, 1'b0);
    check("spur_sticky", err_spurious, 1);
    run_frame(-1, 1'b1, 1'b0);

    // Abandon a frame in ENC with one block in the drain register and one in the FIFO.
    key = 8'($urandom);
    iv  = 8'($urandom);
    steg_ready = 1'b0;
    start = 1'b1;
    tick;
    start = 1'b0;
    for (int b = 0; b < 3; b++) begin
      pt = 8'($urandom);
      shift_block(b, key, iv, pt, -1, 1'b0);
      tick;
      if (b < 2) begin
        aes_done = 1'b1;
        aes_ct   = 8'($urandom);
        tick;
        aes_done = 1'b0;
      end
    end
    check("pre_rst_level", fifo_level, 1);
    check("pre_rst_valid", steg_valid, 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_level", fifo_level, 0);
    check("mid_rst_valid", steg_valid, 0);
    check("mid_rst_payload", steg_payload, 0);
    check("mid_rst_key", aes_key, 0);
    check("mid_rst_iv", aes_iv, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_blk_cnt", blk_cnt, 0);
    check("mid_rst_err", err_spurious, 0);
    tick;
    rst_n = 1'b1;
    got_q.delete();
    exp_q.delete();
    tick;
    run_frame(-1, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
